orbit_pixel_plotter: RTL and testbench

- Consumer side of the orbital particle read port.
- Once per video frame it reads the screen coordinates of two particles through the 2-bit address / 32-bit data read interface.
- It erases each particle's previously drawn pixel, then draws each new pixel into the VGA framebuffer through a valid/ready write port.
- Sits between the orbital computation wrapper and the framebuffer write arbiter.

---
 rtl/orbit_pixel_plotter.sv | 238 +++++++++++++++++++++++
 tb/tb_orbit_pixel_plotter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/orbit_pixel_plotter.sv
// orbit_pixel_plotter
//   Once per video frame, reads the screen coordinates of two orbital
//   particles through a 2-bit address / 32-bit data read port. It erases each
//   particle's previously drawn pixel and then draws each new pixel through a
//   valid/ready framebuffer write port.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   frame_tick   one-cycle pulse that starts an update pass
//   rd_addr      read select: 0=px0, 1=py0, 2=px1, 3=py1
//   rd_data      coordinate word, combinationally valid for the current rd_addr
//   fb_wr_valid  framebuffer write request
//   fb_wr_ready  framebuffer accepts when valid && ready at a clock edge
//   fb_x/fb_y    write pixel coordinates
//   fb_color     write pixel colour
//   busy         high while an update pass is in progress
//   overrun_cnt  saturating count of frame_tick pulses ignored while busy
//
// Write handshake: fb_wr_valid is a decode of the registered state, so it
// does not depend combinationally on fb_wr_ready. fb_x/fb_y/fb_color are
// registered and are reloaded only when a step completes, so they hold
// while valid is high and ready is low. A step completes on the edge where
// valid && ready are both high. The next writing step is presented on the
// following cycle with valid kept high.
//
// A pass runs four steps in a fixed order: erase p0, erase p1, draw p0,
// draw p1. Steps that issue no write are skipped without spending a cycle.
// The first write therefore appears right after the last read cycle, and
// the writes follow one per cycle. Previous-position state is committed once,
// when the pass ends. All erase decisions are made before that commit.
module orbit_pixel_plotter #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter logic [7:0]  COLOR_BG = 8'h00,
  parameter logic [7:0]  COLOR_P0 = 8'hE0,
  parameter logic [7:0]  COLOR_P1 = 8'h1C
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  output logic [1:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        fb_wr_valid,
  input  logic        fb_wr_ready,
  output logic [9:0]  fb_x,
  output logic [8:0]  fb_y,
  output logic [7:0]  fb_color,
  output logic        busy,
  output logic [15:0] overrun_cnt
);

  localparam logic [31:0] W32 = SCREEN_W;
  localparam logic [31:0] H32 = SCREEN_H;

  typedef enum logic [1:0] {IDLE, READ, ERASE, DRAW} state_t;

  state_t      state, state_nx;
  logic [1:0]  rd_cnt, rd_cnt_nx;
  logic        idx, idx_nx;        // particle index within ERASE/DRAW
  logic        load;               // present a new write on the next cycle
  logic        finish;             // pass ends on this edge

  logic [31:0] new_x0, new_y0, new_x1, new_y1;
  logic [31:0] ny1;                // new_y1, or rd_data while it is being read
  logic [9:0]  prev_x0, prev_x1;
  logic [8:0]  prev_y0, prev_y1;
  logic [1:0]  prev_valid;

  logic        in0, in1;
  logic [3:0]  need;               // step writes: {draw1, draw0, erase1, erase0}
  int          start;
  logic        found;
  logic [1:0]  nxt;
  logic [9:0]  wx;
  logic [8:0]  wy;
  logic [7:0]  wc;

  // The last read cycle must make its write decision from rd_data directly,
  // because py1 only reaches its register at that same edge.
  always_comb begin
    ny1 = new_y1;
    if (state == READ && rd_cnt == 2'd3) ny1 = rd_data;
  end

  // Full 32-bit compares: negative source values wrap large and fall off-screen.
  always_comb begin
    in0 = (new_x0 < W32) && (new_y0 < H32);
    in1 = (new_x1 < W32) && (ny1 < H32);
    // If the particle is in bounds, it stays put only when its low bits match
    // the stored pixel. Upper bits are zero whenever it is in bounds.
    need[0] = prev_valid[0] && !(in0 && new_x0[9:0] == prev_x0 && new_y0[8:0] == prev_y0);
    need[1] = prev_valid[1] && !(in1 && new_x1[9:0] == prev_x1 && ny1[8:0] == prev_y1);
    need[2] = in0;
    need[3] = in1;
  end

  // Find the first writing step after the current one (or from step 0 after
  // reads).
  always_comb begin
    start = 0;
    if (state != READ) start = int'({state == DRAW, idx}) + 1;
    found = 1'b0;
    nxt   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && k >= start && need[k]) begin
        found = 1'b1;
        nxt   = 2'(k);
      end
    end
  end

  always_comb begin
    wx = prev_x0;
    wy = prev_y0;
    wc = COLOR_BG;
    case (nxt)
      2'd0: begin wx = prev_x0;      wy = prev_y0;     wc = COLOR_BG; end
      2'd1: begin wx = prev_x1;      wy = prev_y1;     wc = COLOR_BG; end
      2'd2: begin wx = new_x0[9:0];  wy = new_y0[8:0]; wc = COLOR_P0; end
      default: begin wx = new_x1[9:0]; wy = ny1[8:0];  wc = COLOR_P1; end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx  = state;
    rd_cnt_nx = rd_cnt;
    idx_nx    = idx;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_nx  = READ;
          rd_cnt_nx = 2'd0;
        end
      end
      READ: begin
        rd_cnt_nx = rd_cnt + 2'd1;
        if (rd_cnt == 2'd3) begin
          if (found) begin
            load     = 1'b1;
            state_nx = nxt[1] ? DRAW : ERASE;
            idx_nx   = nxt[0];
          end else begin
            finish   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      ERASE, DRAW: begin
        if (fb_wr_ready) begin
          if (found) begin
            load     = 1'b1;
            state_nx = nxt[1] ? DRAW : ERASE;
            idx_nx   = nxt[0];
          end else begin
            finish   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_cnt <= 2'd0;
      idx    <= 1'b0;
    end else begin
      state  <= state_nx;
      rd_cnt <= rd_cnt_nx;
      idx    <= idx_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      new_x0 <= '0;
      new_y0 <= '0;
      new_x1 <= '0;
      new_y1 <= '0;
    end else if (state == READ) begin
      case (rd_cnt)
        2'd0: new_x0 <= rd_data;
        2'd1: new_y0 <= rd_data;
        2'd2: new_x1 <= rd_data;
        default: new_y1 <= rd_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_x0    <= '0;
      prev_y0    <= '0;
      prev_x1    <= '0;
      prev_y1    <= '0;
      prev_valid <= 2'b00;
    end else if (finish) begin
      prev_x0    <= new_x0[9:0];
      prev_y0    <= new_y0[8:0];
      prev_x1    <= new_x1[9:0];
      prev_y1    <= ny1[8:0];
      prev_valid <= {in1, in0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
    end else if (load) begin
      fb_x     <= wx;
      fb_y     <= wy;
      fb_color <= wc;
    end
  end

  // A tick on the cycle the pass returns to IDLE still sees state != IDLE and
  // is counted as ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= '0;
    end else if (frame_tick && state != IDLE && overrun_cnt != 16'hFFFF) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  assign rd_addr     = (state == READ) ? rd_cnt : 2'd0;
  assign fb_wr_valid = (state == ERASE) || (state == DRAW);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_orbit_pixel_plotter.sv
// tb_orbit_pixel_plotter
//   Testbench for orbit_pixel_plotter. A frame-level reference model builds
//   the expected write list for each frame from the erase/draw rules. A monitor
//   pops the expected writes and compares them with each accepted
//   framebuffer transfer. It also checks that the write data stays stable
//   under backpressure.
module tb_orbit_pixel_plotter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic        fb_wr_valid;
  logic        fb_wr_ready = 1'b1;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [7:0]  fb_color;
  logic        busy;
  logic [15:0] overrun_cnt;

  orbit_pixel_plotter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .fb_wr_valid (fb_wr_valid),
    .fb_wr_ready (fb_wr_ready),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_color    (fb_color),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  // Clock.
  always #5 clk = ~clk;

  // Coordinate source: px0, py0, px1, py1.
  logic [31:0] src [4];
  assign rd_data = src[rd_addr];

  // Scoreboard state.
  logic [26:0] exp_q [$];
  int tests  = 0;
  int failed = 0;
  bit rand_ready = 0;

  // Reference model state.
  bit          mp_valid [2];
  logic [31:0] mp_x [2];
  logic [31:0] mp_y [2];
  logic [7:0]  exp_pix [int];
  logic [7:0]  dut_pix [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] pack(input logic [31:0] x, input logic [31:0] y,
                                       input logic [7:0] c);
    logic [9:0] xl;
    logic [8:0] yl;
    xl = x[9:0];
    yl = y[8:0];
    return {xl, yl, c};
  endfunction

  // For each frame, apply every erase and then every draw. This builds the
  // expected write list and the expected screen contents.
  task automatic model_frame(input logic [31:0] x0, input logic [31:0] y0,
                             input logic [31:0] x1, input logic [31:0] y1,
                             output int n);
    logic [31:0] nx [2];
    logic [31:0] ny [2];
    logic [7:0]  col [2];
    bit          in_b [2];
    nx[0] = x0; ny[0] = y0; nx[1] = x1; ny[1] = y1;
    col[0] = 8'hE0; col[1] = 8'h1C;
    n = 0;
    for (int i = 0; i < 2; i++) in_b[i] = (nx[i] < 640) && (ny[i] < 480);
    for (int i = 0; i < 2; i++) begin
      if (mp_valid[i] && (mp_x[i] != nx[i] || mp_y[i] != ny[i] || !in_b[i])) begin
        exp_q.push_back(pack(mp_x[i], mp_y[i], 8'h00));
        exp_pix[int'(mp_x[i]) * 512 + int'(mp_y[i])] = 8'h00;
        n++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (in_b[i]) begin
        exp_q.push_back(pack(nx[i], ny[i], col[i]));
        exp_pix[int'(nx[i]) * 512 + int'(ny[i])] = col[i];
        n++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      mp_x[i] = nx[i];
      mp_y[i] = ny[i];
      mp_valid[i] = in_b[i];
    end
  endtask

  // Monitor: sample on the falling edge and record each accepted transfer.
  logic        held = 1'b0;
  logic [26:0] held_d;
  always @(negedge clk) begin
    logic [26:0] cur;
    cur = {fb_x, fb_y, fb_color};
    if (!reset_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(fb_wr_valid), 32'd1);
        check("hold_data", 32'(cur), 32'(held_d));
      end
      if (fb_wr_valid && fb_wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(cur), 32'h0DEAD);
        end else begin
          check("write", 32'(cur), 32'(exp_q.pop_front()));
        end
        dut_pix[int'(fb_x) * 512 + int'(fb_y)] = fb_color;
        held = 1'b0;
      end else if (fb_wr_valid) begin
        held = 1'b1;
        held_d = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Random ready driver, enabled for the randomized phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      fb_wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Run one frame. timing: check the read sequence and latency (requires
  // ready high, except during the bp window). bp: hold ready low for the
  // first three cycles of the first write. extra: inject two ticks while busy.
  task automatic run_frame(input logic [31:0] x0, input logic [31:0] y0,
                           input logic [31:0] x1, input logic [31:0] y1,
                           input bit timing, input bit bp, input bit extra);
    int n;
    int k;
    model_frame(x0, y0, x1, y1, n);
    src[0] = x0; src[1] = y0; src[2] = x1; src[3] = y1;
    if (bp) fb_wr_ready = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;     // edge T sampled the tick
    for (int c = 0; c < 4; c++) begin
      if (timing) begin
        check("rd_addr", 32'(rd_addr), 32'(c));
        check("busy_read", 32'(busy), 32'd1);
      end
      frame_tick = extra && (c == 0 || c == 2);
      @(posedge clk); #1;
    end
    frame_tick = 1'b0;
    if (timing) check("first_valid", 32'(fb_wr_valid), 32'(n > 0));
    if (bp) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check("bp_valid_held", 32'(fb_wr_valid), 32'd1);
      end
      fb_wr_ready = 1'b1;
    end
    k = 0;
    while (busy && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("pass_done", 32'(busy), 32'd0);
    if (timing) check("busy_fall", 32'(k), 32'(n));
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_coord(input int lim, input logic [31:0] keep);
    int m;
    m = $urandom_range(0, 9);
    if (m == 0) return $urandom();
    if (m == 1) return 32'(lim + $urandom_range(0, 3));
    if (m <= 3) return keep;
    return 32'($urandom_range(0, lim - 1));
  endfunction

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      mp_valid[i] = 0; mp_x[i] = '0; mp_y[i] = '0;
    end
    for (int i = 0; i < 4; i++) src[i] = '0;

    // Reset values.
    #3;
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_valid", 32'(fb_wr_valid), 32'd0);
    check("rst_fb", 32'({fb_x, fb_y, fb_color}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    #14 reset_n = 1'b1;

    // 1: first frame draws only, with exact latency.
    run_frame(100, 50, 200, 60, 1, 0, 0);
    // 2: p0 moves onto p1's old pixel; erases come first so p0 survives.
    run_frame(200, 60, 300, 70, 1, 0, 0);
    check("pixel_200_60", 32'(dut_pix[200 * 512 + 60]), 32'(exp_pix[200 * 512 + 60]));
    check("pixel_200_60_const", 32'(dut_pix[200 * 512 + 60]), 32'hE0);
    // 3: unchanged positions redraw without erasing.
    run_frame(200, 60, 300, 70, 1, 0, 0);
    // 4: backpressure on the first write.
    run_frame(50, 50, 300, 70, 1, 1, 0);
    // 5: off-screen handling.
    run_frame(640, 50, 300, 70, 1, 0, 0);
    run_frame(32'hFFFFFFF6, 20, 300, 479, 1, 0, 0);
    run_frame(10, 10, 639, 479, 1, 0, 0);
    // 6: ticks while busy are counted and ignored.
    run_frame(11, 12, 13, 14, 1, 0, 1);
    check("overrun_cnt", 32'(overrun_cnt), 32'd2);

    // Randomized frames with random ready.
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      run_frame(rand_coord(640, mp_x[0]), rand_coord(480, mp_y[0]),
                rand_coord(640, mp_x[1]), rand_coord(480, mp_y[1]), 0, 0, 0);
    end
    rand_ready = 0;
    @(posedge clk); #1 fb_wr_ready = 1'b0;

    // Reset during a pending write.
    src[0] = 400; src[1] = 400; src[2] = 401; src[3] = 401;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    k = 0;
    while (!fb_wr_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("valid_before_reset", 32'(fb_wr_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_valid_async", 32'(fb_wr_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun_cnt), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 2; i++) mp_valid[i] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    fb_wr_ready = 1'b1;
    run_frame(5, 5, 6, 6, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $fatal(1, "timeout");
  end

endmodule
